// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit and its queue.
package fetch_pkg;

    localparam logic [3:0] HALT_OPCODE = 4'hF;
    localparam int         QUEUE_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } fetch_state_e;

    function automatic logic is_halt(input logic [3:0] opcode);
        return opcode == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Valid/ready channel carrying fetched {pc, instr} pairs to the decoder.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) ();

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0] out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry flushable FIFO of {pc, instr}; flush beats push in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH-1:0] push_pc_i,
    input  logic [DATA_WIDTH-1:0] push_instr_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [1:0]            count_o,
    output logic                  head_valid_o,
    output logic [ADDR_WIDTH-1:0] head_pc_o,
    output logic [DATA_WIDTH-1:0] head_instr_o
);

    localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;

    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop;
    logic             do_push;
    logic [ENTRY_WIDTH-1:0] entry_view [QUEUE_DEPTH];
    logic [ENTRY_WIDTH-1:0] head_entry;

    // A full queue may still take a push when the head leaves this cycle.
    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && !flush_i && ((count_q < 2'(QUEUE_DEPTH)) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
        logic [ENTRY_WIDTH-1:0] ent_q, ent_d;

        always_comb begin
            ent_d = ent_q;
            if (do_push && (wr_ptr_q == 1'(gi))) ent_d = {push_pc_i, push_instr_i};
        end

        always_ff @(posedge clk) begin
            if (!rst_n) ent_q <= '0;
            else        ent_q <= ent_d;
        end

        assign entry_view[gi] = ent_q;
    end

    // Outputs read as zero while empty so stale flushed entries never leak out.
    assign head_entry   = entry_view[rd_ptr_q];
    assign head_valid_o = (count_q != 2'd0);
    assign head_pc_o    = head_valid_o ? head_entry[ENTRY_WIDTH-1:DATA_WIDTH] : '0;
    assign head_instr_o = head_valid_o ? head_entry[DATA_WIDTH-1:0] : '0;
    assign count_o      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, IDLE/FETCH/HALTED control, feeds the decode queue.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic                  branch_valid_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    output logic                  halted_o,
    instr_fetch_if.master         out_if
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  push;
    logic                  flush;
    logic                  pop;
    logic [1:0]            fifo_count;
    logic                  head_valid;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [DATA_WIDTH-1:0] head_instr;

    assign pop = head_valid && out_if.out_ready;

    // Branch outranks halt detection and the normal push; the instruction on
    // instr_i in a branch cycle is discarded.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = FETCH;
            end
            FETCH: begin
                if (branch_valid_i) begin
                    flush = 1'b1;
                    pc_d  = branch_target_i;
                end else if ((fifo_count < 2'(QUEUE_DEPTH)) || pop) begin
                    push = 1'b1;
                    if (is_halt(instr_i[DATA_WIDTH-1 -: 4])) state_d = HALTED;
                    else                                     pc_d    = pc_q + 1'b1;
                end
            end
            HALTED: begin
                if (branch_valid_i) begin
                    flush   = 1'b1;
                    pc_d    = branch_target_i;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_pc_i    (pc_q),
        .push_instr_i (instr_i),
        .pop_i        (pop),
        .flush_i      (flush),
        .count_o      (fifo_count),
        .head_valid_o (head_valid),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr)
    );

    assign pc_o             = pc_q;
    assign halted_o         = (state_q == HALTED);
    assign out_if.out_valid = head_valid;
    assign out_if.out_pc    = head_pc;
    assign out_if.out_instr = head_instr;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the reading end of the instruction memory port. It drives the program counter to the asynchronous-read instruction memory, captures each returned 16-bit instruction with its address into a 2-entry flushable queue, and presents them to the decode stage over a valid/ready handshake. It sits between `instr_mem` and the decoder. Branch redirects from later stages and a HALT opcode control the PC sequence.

## Interface
- `ADDR_WIDTH`, 16, PC / memory address width (word addressed).
- `DATA_WIDTH`, 16, instruction width.
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  one-cycle pulse after the memory has been filled; leaves IDLE.
- `pc_o`  out  ADDR_WIDTH  address to instruction memory (`PC` input of memory).
- `instr_i`  in  DATA_WIDTH  instruction returned by memory for `pc_o`, same cycle.
- `branch_valid_i`  in  1  redirect request.
- `branch_target_i`  in  ADDR_WIDTH  redirect address.
- `out_valid_o`  out  1  queue head valid.
- `out_ready_i`  in  1  decoder accepts head.
- `out_instr_o`  out  DATA_WIDTH  head instruction.
- `out_pc_o`  out  ADDR_WIDTH  head instruction address.
- `halted_o`  out  1  high while in HALTED.

## Operation
- States: IDLE, FETCH, HALTED. Reset -> IDLE.
- IDLE: PC held; no pushes. `start_i` -> FETCH.
- FETCH: each cycle, if queue can accept (count < 2, or count == 2 with head popped this cycle), push {`pc_o`, `instr_i`} and PC <= PC + 1. Otherwise PC holds (stall).
- HALT: a pushed instruction with `instr_i[15:12]` == HALT_OPCODE (4'hF) is queued normally; PC is not incremented; state -> HALTED.
- HALTED: no pushes; queue drains normally. `branch_valid_i` -> FETCH with PC <= target.
- Branch (any state except IDLE): queue flushed (count <= 0), PC <= `branch_target_i`, the instruction on `instr_i` that cycle is discarded, state -> FETCH. Branch in IDLE is ignored.
- Priority per cycle: reset > branch > halt detection > normal push.
- Pop: `out_valid_o && out_ready_i` removes head. A pop in the same cycle as a branch completes (decoder owns that instruction); all remaining entries are flushed.
- `out_valid_o` = (count != 0); `out_instr_o`/`out_pc_o` are the head entry, held stable while valid and not ready.
- PC arithmetic modulo 2^ADDR_WIDTH: 16'hFFFF + 1 -> 16'h0000, no flag.
- `start_i` while in FETCH or HALTED is ignored.

## Timing
- Reset values: `pc_o` = RESET_PC, `out_valid_o` = 0, `out_instr_o` = 0, `out_pc_o` = 0, `halted_o` = 0, count = 0, state IDLE.
- `pc_o` is a register output; memory read is combinational, so `instr_i` is sampled at the end of the cycle in which `pc_o` is presented.
- `start_i` at cycle N: FETCH in N+1, first push at end of N+1, `out_valid_o` high in N+2.
- Fetch-to-valid latency 1 cycle; sustained throughput 1 instruction/cycle with `out_ready_i` held high.
- Branch at cycle B: `pc_o` = target in B+1; `out_valid_o` low in B+1; target instruction valid in B+2.
- `halted_o` rises the cycle after the HALT push.
- Reset mid-fetch or mid-halt: all state returns to reset values at the next edge; queue contents lost.

## Structure
- Package `fetch_pkg`: HALT_OPCODE (4'hF), state enum {IDLE, FETCH, HALTED}, queue depth constant (2).
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO of {pc, instr} with push, pop, flush, count; flush wins over push in the same cycle.
- Top holds the PC register, state machine, and push/flush logic.

## Test plan
- Reset, `start_i`, memory 0..3 = 16'h1001, 16'h2002, 16'h3003, 16'hF000, ready high -> outputs (pc,instr) (0,1001),(1,2002),(2,3003),(3,F000) on consecutive cycles; `halted_o` = 1; `pc_o` stays 3.
- Ready low for 5 cycles after start -> queue fills at 2; `pc_o` stops at RESET_PC+2; head (0,1001) stable; release -> no instruction lost or duplicated.
- Branch to 16'h0040 while 2 entries queued and head popped same cycle -> popped entry counted delivered, other flushed; next valid is (0040, mem[0x40]) two cycles after branch.
- In HALTED, branch to 16'h0010 -> `halted_o` falls, fetch resumes from 0x0010.
- Branch to 16'hFFFE with non-HALT contents -> pcs FFFE, FFFF, 0000, 0001 delivered.
- Assert `rst_n` low mid-stream with count = 2 -> next cycle all outputs at reset values, state IDLE, `start_i` required to restart.
